// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants, grant-select type and the access legality
// helper for the data-memory arbiter.
package dm_arb_pkg;

    // DM size encoding: 0 is a read, otherwise the number of bytes written.
    localparam logic [2:0] SZ_READ = 3'd0;
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // Which requester owns the DM ports this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_sel_e;

    // Legal when the size is a known encoding and halfword/word accesses are
    // naturally aligned. Only the low address bits matter, so only those are
    // passed in.
    function automatic logic size_legal(input logic [1:0] addr, input logic [2:0] size);
        logic ok;
        case (size)
            SZ_READ: ok = 1'b1;
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (addr[0] == 1'b0);
            SZ_WORD: ok = (addr == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_arb_resp.sv
// dm_arb_resp: per-port response register. Captures read data / error on the
// edge that ends the grant cycle and presents them for exactly one cycle.
// Reset is asynchronous so a pending response vanishes the moment reset asserts.
module dm_arb_resp
    import dm_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [31:0] rdata_in,
    input  logic        err_in,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    logic        resp_valid_r;
    logic [31:0] rdata_r;
    logic        err_r;

    // Response register: load on acceptance, otherwise drop the valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
        end else if (accept) begin
            resp_valid_r <= 1'b1;
            rdata_r      <= rdata_in;
            err_r        <= err_in;
        end else begin
            resp_valid_r <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_r;
    assign rdata      = rdata_r;
    assign err        = err_r;

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data memory between the CPU MEM stage and a DMA
// requester. CPU has fixed priority; a saturating starvation counter forces
// the DMA through after STARVE_LIMIT consecutive CPU wins.
// Optional macro DM_ARB_ALIGN_CHECK_EN: reject misaligned/illegal sizes
// (accepted, no write, err=1, rdata=0). Without it, err is always 0 and
// every size passes straight through to the DM.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_size,
    output logic        dma_resp_valid,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic [31:0] dm_address,
    output logic [31:0] dm_data_in,
    output logic [2:0]  dm_size,
    input  logic [31:0] dm_data_out
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    gnt_sel_e    gnt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_nxt_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [2:0]  sel_size_s;
    logic        legal_s;
    logic        reject_s;
    logic [31:0] resp_data_s;

    // Grant decision; nothing is granted while reset is held so no DM write can slip out.
    always_comb begin
        gnt_s = GNT_NONE;
        if (!reset) begin
            gnt_s = GNT_NONE;
        end else if (cpu_req_valid && dma_req_valid) begin
            if (starve_cnt_r == LIMIT_C) begin
                gnt_s = GNT_DMA;
            end else begin
                gnt_s = GNT_CPU;
            end
        end else if (cpu_req_valid) begin
            gnt_s = GNT_CPU;
        end else if (dma_req_valid) begin
            gnt_s = GNT_DMA;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Request mux: route the granted port's fields, zeros when idle.
    always_comb begin
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        sel_size_s  = SZ_READ;
        case (gnt_s)
            GNT_CPU: begin
                sel_addr_s  = cpu_addr;
                sel_wdata_s = cpu_wdata;
                sel_size_s  = cpu_size;
            end
            GNT_DMA: begin
                sel_addr_s  = dma_addr;
                sel_wdata_s = dma_wdata;
                sel_size_s  = dma_size;
            end
            default: begin
                sel_addr_s  = 32'd0;
                sel_wdata_s = 32'd0;
                sel_size_s  = SZ_READ;
            end
        endcase
    end

`ifdef DM_ARB_ALIGN_CHECK_EN
    assign legal_s = size_legal(sel_addr_s[1:0], sel_size_s);
`else
    assign legal_s = 1'b1;
`endif

    assign reject_s   = (gnt_s != GNT_NONE) && !legal_s;
    assign dm_address = sel_addr_s;
    assign dm_data_in = sel_wdata_s;
    assign dm_size    = legal_s ? sel_size_s : SZ_READ;

    // Reads return the DM word; writes and rejected accesses return zero.
    assign resp_data_s = ((sel_size_s == SZ_READ) && legal_s) ? dm_data_out : 32'd0;

    assign cpu_req_ready = (gnt_s == GNT_CPU);
    assign dma_req_ready = (gnt_s == GNT_DMA);

    // Starvation counter next value: count CPU wins over a waiting DMA, clear otherwise.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (!dma_req_valid || (gnt_s == GNT_DMA)) begin
            starve_nxt_s = 4'd0;
        end else if (gnt_s == GNT_CPU) begin
            if (starve_cnt_r >= LIMIT_C) begin
                starve_nxt_s = LIMIT_C;
            end else begin
                starve_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    dm_arb_resp u_cpu_resp (
        .clk        (clk),
        .reset      (reset),
        .accept     (gnt_s == GNT_CPU),
        .rdata_in   (resp_data_s),
        .err_in     (reject_s),
        .resp_valid (cpu_resp_valid),
        .rdata      (cpu_rdata),
        .err        (cpu_err)
    );

    dm_arb_resp u_dma_resp (
        .clk        (clk),
        .reset      (reset),
        .accept     (gnt_s == GNT_DMA),
        .rdata_in   (resp_data_s),
        .err_in     (reject_s),
        .resp_valid (dma_resp_valid),
        .rdata      (dma_rdata),
        .err        (dma_err)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model that keeps
// its own byte-array image of memory.
module tb_dm_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req_valid = 1'b0, dma_req_valid = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, dma_addr = 32'd0, dma_wdata = 32'd0;
    logic [2:0]  cpu_size = 3'd0, dma_size = 3'd0;
    logic        cpu_req_ready, dma_req_ready, cpu_resp_valid, dma_resp_valid, cpu_err, dma_err;
    logic [31:0] cpu_rdata, dma_rdata, dm_address, dm_data_in, dm_data_out;
    logic [2:0]  dm_size;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_size(dma_size),
        .dma_resp_valid(dma_resp_valid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .dm_address(dm_address), .dm_data_in(dm_data_in), .dm_size(dm_size),
        .dm_data_out(dm_data_out)
    );

    // Data memory seen by the DUT: 256 bytes, little-endian, bytewise unaligned access.
    logic [7:0] mem [256];
    assign dm_data_out = {mem[dm_address[7:0] + 8'd3], mem[dm_address[7:0] + 8'd2],
                          mem[dm_address[7:0] + 8'd1], mem[dm_address[7:0]]};

    // DM write port: commits min(size,4) bytes at the clock edge.
    always @(posedge clk) begin
        if (dm_size != 3'd0) begin
            for (int i = 0; i < ((dm_size > 3'd4) ? 4 : int'(dm_size)); i++)
                mem[dm_address[7:0] + 8'(i)] <= dm_data_in[8*i +: 8];
        end
    end

    // Model's own memory image.
    logic [7:0] shm [256];

    function automatic logic [31:0] sh_rd(input logic [7:0] a);
        return {shm[a + 8'd3], shm[a + 8'd2], shm[a + 8'd1], shm[a]};
    endfunction

    function automatic logic model_legal(input logic [31:0] a, input logic [2:0] s);
`ifdef DM_ARB_ALIGN_CHECK_EN
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd2 && a % 2 == 0) || (s == 3'd4 && a % 4 == 0);
`else
        return (a == a) && (s == s);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic        exp_cv = 1'b0, exp_dv = 1'b0, exp_ce = 1'b0, exp_de = 1'b0;
    logic [31:0] exp_cr = 32'd0, exp_dr = 32'd0;
    int          wait_cnt = 0;
    logic        last_gc = 1'b0, last_gd = 1'b0;

    // Compare process: every negedge, check outputs against the model and advance it.
    always @(negedge clk) begin
        logic gc, gd, rej;
        logic [31:0] sa, sw, rd;
        logic [2:0] ss;
        if (!reset) begin
            chk("rst_cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
            chk("rst_dma_resp_valid", 32'(dma_resp_valid), 32'd0);
            chk("rst_readies", 32'({dma_req_ready, cpu_req_ready}), 32'd0);
            chk("rst_dm_size", 32'(dm_size), 32'd0);
            exp_cv = 1'b0; exp_dv = 1'b0; wait_cnt = 0; last_gc = 1'b0; last_gd = 1'b0;
        end else begin
            chk("cpu_resp_valid", 32'(cpu_resp_valid), 32'(exp_cv));
            if (exp_cv) begin
                chk("cpu_rdata", cpu_rdata, exp_cr);
                chk("cpu_err", 32'(cpu_err), 32'(exp_ce));
            end
            chk("dma_resp_valid", 32'(dma_resp_valid), 32'(exp_dv));
            if (exp_dv) begin
                chk("dma_rdata", dma_rdata, exp_dr);
                chk("dma_err", 32'(dma_err), 32'(exp_de));
            end
            // CPU wins unless DMA has already waited through LIM CPU grants.
            gc = cpu_req_valid && !(dma_req_valid && wait_cnt == LIM);
            gd = dma_req_valid && !gc;
            sa = gc ? cpu_addr : (gd ? dma_addr : 32'd0);
            sw = gc ? cpu_wdata : (gd ? dma_wdata : 32'd0);
            ss = gc ? cpu_size : (gd ? dma_size : 3'd0);
            rej = (gc || gd) && !model_legal(sa, ss);
            chk("cpu_req_ready", 32'(cpu_req_ready), 32'(gc));
            chk("dma_req_ready", 32'(dma_req_ready), 32'(gd));
            chk("dm_address", dm_address, sa);
            chk("dm_data_in", dm_data_in, sw);
            chk("dm_size", 32'(dm_size), rej ? 32'd0 : 32'(ss));
            rd = (!rej && ss == 3'd0) ? sh_rd(sa[7:0]) : 32'd0;
            exp_cv = gc; exp_dv = gd;
            if (gc) begin exp_cr = rd; exp_ce = rej; end
            if (gd) begin exp_dr = rd; exp_de = rej; end
            if ((gc || gd) && !rej && ss != 3'd0) begin
                for (int i = 0; i < ((ss > 3'd4) ? 4 : int'(ss)); i++)
                    shm[sa[7:0] + 8'(i)] = sw[8*i +: 8];
            end
            if (!dma_req_valid || gd) wait_cnt = 0;
            else if (gc && wait_cnt < LIM) wait_cnt = wait_cnt + 1;
            last_gc = gc; last_gd = gd;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic v, input logic [31:0] a, input logic [31:0] w, input logic [2:0] s);
        cpu_req_valid = v; cpu_addr = a; cpu_wdata = w; cpu_size = s;
    endtask

    task automatic dma_drive(input logic v, input logic [31:0] a, input logic [31:0] w, input logic [2:0] s);
        dma_req_valid = v; dma_addr = a; dma_wdata = w; dma_size = s;
    endtask

    task automatic gen(output logic [31:0] a, output logic [31:0] w, output logic [2:0] s);
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) s = 3'd0;
        else if (r == 4) s = 3'd1;
        else if (r == 5) s = 3'd2;
        else if (r <= 7) s = 3'd4;
        else if (r == 8) s = 3'd3;
        else s = 3'($urandom_range(5, 7));
        a = {24'($urandom), 8'($urandom_range(0, 63))};
        w = $urandom;
    endtask

    initial begin
        logic [31:0] a, w;
        logic [2:0] s;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'd0; shm[i] = 8'd0; end
        #1 reset = 1'b0;
        // Reset: outputs quiet and a pending write is not granted.
        cpu_drive(1'b1, 32'h10, 32'hFFFF_FFFF, 3'd4);
        #1;
        chk("init_ready", 32'(cpu_req_ready), 32'd0);
        chk("init_dm_size", 32'(dm_size), 32'd0);
        chk("init_resp", 32'({cpu_resp_valid, dma_resp_valid}), 32'd0);
        chk("init_rdata", cpu_rdata | dma_rdata, 32'd0);
        chk("init_err", 32'({cpu_err, dma_err}), 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // CPU word write then read back.
        cpu_drive(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd4);
        cyc();
        chk("t1_wr_resp", 32'(cpu_resp_valid), 32'd1);
        chk("t1_wr_rdata", cpu_rdata, 32'd0);
        cpu_drive(1'b1, 32'h10, 32'd0, 3'd0);
        cyc();
        chk("t1_rd_resp", 32'(cpu_resp_valid), 32'd1);
        chk("t1_rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // Continuous contention: C,C,C,C,D repeating.
        cpu_drive(1'b1, 32'h0, 32'd0, 3'd0);
        dma_drive(1'b1, 32'h4, 32'd0, 3'd0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("starve_seq", 32'({dma_req_ready, cpu_req_ready}), (k % 5 == 4) ? 32'd2 : 32'd1);
            cyc();
        end
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // DMA byte write, CPU word read of the containing word.
        dma_drive(1'b1, 32'h21, 32'h0000_005A, 3'd1);
        cyc();
        dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cpu_drive(1'b1, 32'h20, 32'd0, 3'd0);
        cyc();
        chk("t3_resp", 32'(cpu_resp_valid), 32'd1);
        chk("t3_rdata", cpu_rdata, 32'h0000_5A00);
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // Reset mid-cycle with a response pending and a write requested.
        cpu_drive(1'b1, 32'h40, 32'hCAFE_F00D, 3'd4);
        cyc();
        cpu_drive(1'b1, 32'h30, 32'h1234_5678, 3'd4);
        chk("t4_pending", 32'(cpu_resp_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_dm_size", 32'(dm_size), 32'd0);
        chk("t4_ready", 32'(cpu_req_ready), 32'd0);
        chk("t4_resp_drop", 32'({cpu_resp_valid, dma_resp_valid}), 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        cpu_drive(1'b1, 32'h30, 32'd0, 3'd0);
        cyc();
        chk("t4_nowrite", cpu_rdata, 32'd0);
        cpu_drive(1'b1, 32'h40, 32'd0, 3'd0);
        cyc();
        chk("t4_prior_write", cpu_rdata, 32'hCAFE_F00D);
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // Misaligned word store at 0x53.
        cpu_drive(1'b1, 32'h53, 32'h1122_3344, 3'd4);
        #1;
`ifdef DM_ARB_ALIGN_CHECK_EN
        chk("t5_dm_size", 32'(dm_size), 32'd0);
`else
        chk("t5_dm_size", 32'(dm_size), 32'd4);
`endif
        chk("t5_ready", 32'(cpu_req_ready), 32'd1);
        cyc();
        chk("t5_resp", 32'(cpu_resp_valid), 32'd1);
        chk("t5_rdata", cpu_rdata, 32'd0);
`ifdef DM_ARB_ALIGN_CHECK_EN
        chk("t5_err", 32'(cpu_err), 32'd1);
`else
        chk("t5_err", 32'(cpu_err), 32'd0);
`endif
        cpu_drive(1'b1, 32'h50, 32'd0, 3'd0);
        cyc();
`ifdef DM_ARB_ALIGN_CHECK_EN
        chk("t5_rd50", cpu_rdata, 32'd0);
`else
        chk("t5_rd50", cpu_rdata, 32'h4400_0000);
`endif
        cpu_drive(1'b1, 32'h54, 32'd0, 3'd0);
        cyc();
`ifdef DM_ARB_ALIGN_CHECK_EN
        chk("t5_rd54", cpu_rdata, 32'd0);
`else
        chk("t5_rd54", cpu_rdata, 32'h0011_2233);
`endif
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // DMA withdraws while waiting: no response, counter restarts.
        cpu_drive(1'b1, 32'h8, 32'd0, 3'd0);
        dma_drive(1'b1, 32'hC, 32'd0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t6_cpu_wins", 32'(cpu_req_ready), 32'd1);
            cyc();
        end
        dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_no_dma_resp", 32'(dma_resp_valid), 32'd0);
        end
        dma_drive(1'b1, 32'hC, 32'd0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t6_restart_seq", 32'({dma_req_ready, cpu_req_ready}), (k == 4) ? 32'd2 : 32'd1);
            cyc();
        end
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc();

        // Random traffic; requests hold until granted, occasionally withdrawn.
        for (int n = 0; n < 3000; n++) begin
            if (cpu_req_valid && !last_gc) begin
                if ($urandom_range(0, 99) < 4) cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
            end else if ($urandom_range(0, 99) < (cpu_req_valid ? 70 : 40)) begin
                gen(a, w, s);
                cpu_drive(1'b1, a, w, s);
            end else begin
                cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
            end
            if (dma_req_valid && !last_gd) begin
                if ($urandom_range(0, 99) < 4) dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
            end else if ($urandom_range(0, 99) < (dma_req_valid ? 60 : 40)) begin
                gen(a, w, s);
                dma_drive(1'b1, a, w, s);
            end else begin
                dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
            end
            cyc();
        end
        cpu_drive(1'b0, 32'd0, 32'd0, 3'd0);
        dma_drive(1'b0, 32'd0, 32'd0, 3'd0);
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
